// File: rtl/if_fetch_buf_pkg.sv
// Shared widths, reset polarity and sizing helper for the instruction-fetch buffer.
package if_fetch_buf_pkg;

    localparam int   INST_ADDR_W = 32;
    localparam int   INST_BUS_W  = 32;
    localparam int   FETCH_DEPTH = 2;
    localparam logic RST_ACTIVE  = 1'b1;

    // Bits needed to hold any value in 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/if_slot_queue.sv
// Circular store of {pc, inst, filled} slots with separate alloc/fill/head pointers.
module if_slot_queue
    import if_fetch_buf_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = INST_BUS_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_alloc,
    input  logic [ADDR_W-1:0]            i_alloc_pc,
    input  logic                         i_fill,
    input  logic [INST_W-1:0]            i_fill_inst,
    input  logic                         i_pop,
    input  logic                         i_clear,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_unfilled,
    output logic                         o_head_filled,
    output logic [ADDR_W-1:0]            o_head_pc,
    output logic [INST_W-1:0]            o_head_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [ADDR_W-1:0] r_pc     [DEPTH];
    logic [INST_W-1:0] r_inst   [DEPTH];
    logic [DEPTH-1:0]  r_filled;
    logic [PTR_W-1:0]  r_alloc_ptr;
    logic [PTR_W-1:0]  r_fill_ptr;
    logic [PTR_W-1:0]  r_head_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_unfilled;

    // Alloc always targets a free slot and fill an allocated-unfilled one, so they never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
            r_unfilled  <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
            r_unfilled  <= '0;
        end else begin
            if (i_alloc) begin
                r_pc[r_alloc_ptr]     <= i_alloc_pc;
                r_filled[r_alloc_ptr] <= 1'b0;
                r_alloc_ptr           <= r_alloc_ptr + 1'b1;
            end
            if (i_fill) begin
                r_inst[r_fill_ptr]   <= i_fill_inst;
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + 1'b1;
            end
            if (i_pop) begin
                r_head_ptr <= r_head_ptr + 1'b1;
            end
            r_count    <= r_count + CNT_W'(i_alloc) - CNT_W'(i_pop);
            r_unfilled <= r_unfilled + CNT_W'(i_alloc) - CNT_W'(i_fill);
        end
    end

    assign o_count       = r_count;
    assign o_unfilled    = r_unfilled;
    assign o_head_filled = r_filled[r_head_ptr];
    assign o_head_pc     = r_pc[r_head_ptr];
    assign o_head_inst   = r_inst[r_head_ptr];

endmodule

// File: rtl/if_fetch_buf.sv
// Fetch stage: gates in-order imem requests on buffer space, buffers {pc, inst} for decode,
// and discards stale responses after a redirect flush.
module if_fetch_buf
    import if_fetch_buf_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = INST_BUS_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_advance_o,
    input  logic              flush_i,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              proto_err_o
);

    localparam int CNT_W  = cnt_w(DEPTH);
    localparam int DROP_W = cnt_w(2 * DEPTH);

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_unfilled;
    logic              w_head_filled;
    logic [ADDR_W-1:0] w_head_pc;
    logic [INST_W-1:0] w_head_inst;
    logic              w_req_valid;
    logic              w_fire;
    logic              w_id_valid;
    logic              w_pop;
    logic              w_fill;
    logic [DROP_W-1:0] w_drop_sum;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              r_proto_err;

    // Space is judged on the registered count only; a same-cycle pop does not free a slot.
    assign w_req_valid = !rst && !flush_i && (w_count < CNT_W'(DEPTH));
    assign w_fire      = w_req_valid && imem_req_ready;
    assign w_id_valid  = !rst && !flush_i && w_head_filled && (w_count != '0);
    assign w_pop       = w_id_valid && id_ready_i;
    assign w_fill      = imem_rsp_valid && !flush_i && (r_drop_cnt == '0) && (w_unfilled != '0);
    assign w_drop_sum  = r_drop_cnt + DROP_W'(w_unfilled);

    if_slot_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_slots (
        .clk           (clk),
        .rst           (rst),
        .i_alloc       (w_fire),
        .i_alloc_pc    (pc_i),
        .i_fill        (w_fill),
        .i_fill_inst   (imem_rsp_data),
        .i_pop         (w_pop),
        .i_clear       (flush_i),
        .o_count       (w_count),
        .o_unfilled    (w_unfilled),
        .o_head_filled (w_head_filled),
        .o_head_pc     (w_head_pc),
        .o_head_inst   (w_head_inst)
    );

    // A response landing in the flush cycle is the oldest stale one, so it consumes one drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_drop_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else if (flush_i) begin
            if (imem_rsp_valid && (w_drop_sum != '0)) begin
                r_drop_cnt <= w_drop_sum - 1'b1;
            end else begin
                r_drop_cnt <= w_drop_sum;
            end
            if (imem_rsp_valid && (w_drop_sum == '0)) begin
                r_proto_err <= 1'b1;
            end
        end else if (imem_rsp_valid) begin
            if (r_drop_cnt != '0) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end else if (w_unfilled == '0) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign pc_advance_o   = w_fire;
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = rst ? '0 : pc_i;
    assign id_valid_o     = w_id_valid;
    assign id_pc_o        = w_head_pc;
    assign id_inst_o      = w_head_inst;
    assign proto_err_o    = r_proto_err;

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: queue-level reference model, in-order memory model, directed scenarios.
module tb_if_fetch_buf;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] pc_i = '0;
    logic              pc_advance_o;
    logic              flush_i = 1'b0;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b1;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid = 1'b0;
    logic [INST_W-1:0] imem_rsp_data = '0;
    logic              id_valid_o;
    logic              id_ready_i = 1'b1;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic              proto_err_o;

    if_fetch_buf dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .pc_advance_o   (pc_advance_o),
        .flush_i        (flush_i),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid_o     (id_valid_o),
        .id_ready_i     (id_ready_i),
        .id_pc_o        (id_pc_o),
        .id_inst_o      (id_inst_o),
        .proto_err_o    (proto_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        bit                filled;
    } ent_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } mreq_t;

    ent_t              mq[$];
    mreq_t             mem_q[$];
    logic [ADDR_W-1:0] dlv_pc_q[$];
    logic [INST_W-1:0] dlv_inst_q[$];

    int   cyc = 0;
    int   mem_lat = 1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   m_drop = 0;
    int   m_unf;
    bit   m_proto = 0;
    bit   last_fire = 0;
    bit   e_req, e_fire, e_idv, found;
    ent_t tmp;

    function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_dlv(input int idx, input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst);
        if (idx >= dlv_pc_q.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL dlv_missing[%0d]: got %0d deliveries, want pc 0x%0h", idx, dlv_pc_q.size(), pc);
        end else begin
            chk($sformatf("dlv_pc[%0d]", idx), dlv_pc_q[idx], pc);
            chk($sformatf("dlv_inst[%0d]", idx), dlv_inst_q[idx], inst);
        end
    endtask

    // PC register and in-order memory: response for a fire at cycle v appears at v+mem_lat.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (last_fire && !rst) pc_i = pc_i + 32'd4;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Reference model and per-cycle compare.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_req_addr", imem_req_addr, 0);
            chk("rst_pc_advance", pc_advance_o, 0);
            chk("rst_id_valid", id_valid_o, 0);
            chk("rst_id_pc", id_pc_o, 0);
            chk("rst_id_inst", id_inst_o, 0);
            chk("rst_proto_err", proto_err_o, 0);
            mq.delete();
            m_drop    = 0;
            m_proto   = 0;
            last_fire = 0;
        end else begin
            m_unf = 0;
            foreach (mq[i]) if (!mq[i].filled) m_unf++;
            e_req  = !flush_i && (mq.size() < DEPTH);
            e_fire = e_req && imem_req_ready;
            e_idv  = !flush_i && (mq.size() > 0) && mq[0].filled;
            chk("req_valid", imem_req_valid, e_req);
            chk("pc_advance", pc_advance_o, e_fire);
            chk("id_valid", id_valid_o, e_idv);
            chk("proto_err", proto_err_o, m_proto);
            if (e_req) chk("req_addr", imem_req_addr, pc_i);
            if (e_idv) begin
                chk("id_pc", id_pc_o, mq[0].pc);
                chk("id_inst", id_inst_o, mq[0].inst);
            end
            if (id_valid_o && id_ready_i) begin
                dlv_pc_q.push_back(id_pc_o);
                dlv_inst_q.push_back(id_inst_o);
            end
            if (flush_i) begin
                m_drop += m_unf;
                mq.delete();
                if (imem_rsp_valid) begin
                    if (m_drop > 0) m_drop--;
                    else m_proto = 1;
                end
            end else begin
                if (e_idv && id_ready_i) void'(mq.pop_front());
                if (imem_rsp_valid) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else if (m_unf > 0) begin
                        found = 0;
                        for (int i = 0; i < mq.size(); i++) begin
                            if (!found && !mq[i].filled) begin
                                tmp        = mq[i];
                                tmp.inst   = imem_rsp_data;
                                tmp.filled = 1;
                                mq[i]      = tmp;
                                found      = 1;
                            end
                        end
                    end else begin
                        m_proto = 1;
                    end
                end
                if (e_fire) begin
                    tmp.pc     = pc_i;
                    tmp.inst   = '0;
                    tmp.filled = 0;
                    mq.push_back(tmp);
                    mem_q.push_back('{addr: pc_i, due: cyc + mem_lat});
                end
            end
            last_fire = e_fire;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Releases reset in the current cycle, which becomes cycle 0 of the next scenario.
    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        mem_q.delete();
        pc_i    = '0;
        flush_i = 1'b0;
        cycles(1);
        rst = 1'b0;
        dlv_pc_q.delete();
        dlv_inst_q.delete();
    endtask

    initial begin
        // Power-on reset, then a free-running stream.
        cycles(3);
        rst = 1'b0;
        #1;
        chk("t1_req_valid_after_rst", imem_req_valid, 1);
        chk("t1_req_addr_after_rst", imem_req_addr, 32'h0);
        cycles(12);
        chk_dlv(0, 32'h0, 32'h1357_9BDF);
        chk_dlv(1, 32'h4, 32'h1357_9BDB);
        chk_dlv(2, 32'h8, 32'h1357_9BD7);

        // Reset in the middle of the stream with responses still due.
        do_reset();
        #1;
        chk("t1_req_valid_after_midrst", imem_req_valid, 1);
        chk("t1_req_addr_after_midrst", imem_req_addr, 32'h0);

        // Decode stall from cycle 0: two fetches then hold.
        id_ready_i = 1'b0;
        cycles(4);
        #1;
        chk("t3_stall_pc_advance", pc_advance_o, 0);
        chk("t3_stall_req_valid", imem_req_valid, 0);
        chk("t3_stall_id_valid", id_valid_o, 1);
        chk("t3_stall_id_pc", id_pc_o, 32'h0);
        id_ready_i = 1'b1;
        cycles(10);
        chk_dlv(0, 32'h0, 32'h1357_9BDF);
        chk_dlv(1, 32'h4, 32'h1357_9BDB);
        chk_dlv(2, 32'h8, 32'h1357_9BD7);

        // Flush with two fetches outstanding on a 3-cycle memory.
        mem_lat = 3;
        do_reset();
        cycles(2);
        flush_i = 1'b1;
        pc_i    = 32'h100;
        #1;
        chk("t4_flush_req_valid", imem_req_valid, 0);
        cycles(1);
        flush_i = 1'b0;
        cycles(14);
        chk_dlv(0, 32'h100, 32'h1357_9ADF);
        chk_dlv(1, 32'h104, 32'h1357_9ADB);
        chk("t4_proto_err", proto_err_o, 0);

        // Flush coinciding with a response and a would-be decode handshake.
        mem_lat = 2;
        do_reset();
        cycles(3);
        flush_i = 1'b1;
        pc_i    = 32'h200;
        #1;
        chk("t5_flush_id_valid", id_valid_o, 0);
        cycles(1);
        flush_i = 1'b0;
        cycles(12);
        chk_dlv(0, 32'h200, 32'h1357_99DF);
        chk_dlv(1, 32'h204, 32'h1357_99DB);
        chk("t5_proto_err", proto_err_o, 0);

        // Spurious response while the buffer is full of completed fetches.
        mem_lat = 1;
        do_reset();
        id_ready_i = 1'b0;
        cycles(5);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        #1;
        chk("t6_proto_err_before", proto_err_o, 0);
        cycles(1);
        #1;
        chk("t6_proto_err_rise", proto_err_o, 1);
        cycles(3);
        chk("t6_proto_err_hold", proto_err_o, 1);
        chk("t6_head_pc_kept", id_pc_o, 32'h0);
        chk("t6_head_inst_kept", id_inst_o, 32'h1357_9BDF);
        id_ready_i = 1'b1;
        cycles(6);
        chk_dlv(0, 32'h0, 32'h1357_9BDF);
        chk_dlv(1, 32'h4, 32'h1357_9BDB);
        chk("t6_proto_err_sticky", proto_err_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
